hx8352_fill_sequencer: RTL and testbench
========================================

Name: hx8352_fill_sequencer

Overview:
Sequences the HX8352 LCD bus controller to paint a solid-colour rectangle. It accepts one rectangle request, issues the window-set register writes, issues the GRAM-write command, then streams the pixel words. Each word goes out through the bus controller's step/busy handshake. It sits between the drawing logic and the HX8352 bus controller, and is the bus controller's only master.

Parameters:
X_W, 9, width of the x coordinate (column, 0..399 range supported)
Y_W, 9, width of the y coordinate (row)
TIMEOUT, 64, cycles allowed for bus_busy to rise after a step (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  1  start request; sampled only when ready=1
x0  in  X_W  window start column
x1  in  X_W  window end column (inclusive)
y0  in  Y_W  window start row
y1  in  Y_W  window end row (inclusive)
color  in  16  RGB565 fill value
ready  out  1  high when IDLE and a request can be accepted
done  out  1  one-cycle pulse when the last pixel transfer has completed
err  out  1  one-cycle pulse on a rejected request or a timeout
bus_busy  in  1  busy output of the bus controller
bus_data  out  16  word presented to the bus controller
bus_dc  out  1  0 = command (register index), 1 = data
bus_step  out  1  transfer strobe; the bus controller is rising-edge sensitive

Behaviour:
- Reset values: ready=0, done=0, err=0, bus_step=0, bus_dc=0, bus_data=0, all counters 0. The FSM is in IDLE; ready rises on the first clock after rst deasserts.
- Request capture:
  - On req=1 with ready=1, latch x0, x1, y0, y1 and color.
  - If x1<x0 or y1<y0: pulse err the next cycle, stay in IDLE, issue no transfers.
  - Otherwise set pixel count N=(x1-x0+1)*(y1-y0+1), held in an X_W+Y_W bit counter.
- Transfer list, in order:
  - 16 window transfers, as pairs of (command = register, data = value):
    (0x02, x0[15:8]), (0x03, x0[7:0]), (0x04, x1[15:8]), (0x05, x1[7:0]),
    (0x06, y0[15:8]), (0x07, y0[7:0]), (0x08, y1[15:8]), (0x09, y1[7:0]).
  - Coordinates are zero-extended to 16 bits; data values occupy bus_data[7:0] with upper bits 0.
  - Then command 0x22.
  - Then N data words equal to color.
- Per-transfer handshake FSM: ISSUE -> WAIT_ACK -> WAIT_DONE.
  - ISSUE is entered only when bus_busy=0. It drives bus_step=1 for exactly one cycle, with bus_data/bus_dc valid.
  - WAIT_ACK: bus_step=0; wait for bus_busy=1.
  - WAIT_DONE: wait for bus_busy=0, then advance the list index or pixel counter.
  - bus_data and bus_dc stay stable from ISSUE until bus_busy falls.
- Timing against the bus controller: step at cycle t, busy rises t+1, busy falls t+3, next ISSUE at t+4. That is 4 cycles per transfer.
- After the last pixel's WAIT_DONE: pulse done, return to IDLE, drive ready=1 on the following cycle.
- ready=0 throughout a fill; req during a fill is ignored and not queued.
- bus_busy=1 in IDLE (for example just after a bus reset) delays the first ISSUE until it clears.
- Asynchronous reset mid-fill aborts immediately, with no done pulse.

Optional Feature:
HX8352_STEP_TIMEOUT_EN
- Defined: a counter runs in WAIT_ACK. If bus_busy is still 0 after TIMEOUT cycles, the block pulses err, abandons the fill without a done pulse, and returns to IDLE.
- Not defined: WAIT_ACK waits indefinitely and err comes only from rejected requests.

Test Plan:
- Fill x0=10, x1=11, y0=20, y1=20, color=0xF800 with a model bus controller.
  Required: 19 transfers in order (C02,D00)(C03,D0A)(C04,D00)(C05,D0B)(C06,D00)(C07,D14)(C08,D00)(C09,D14)(C22)(D F800)x2.
  Transfer starts 4 cycles apart; one done pulse; ready back 1 cycle later.
- Fill x0=0, x1=399, y0=0, y1=239.
  Required: data for register 0x05 is 0x8F, for 0x04 is 0x01; exactly 96000 colour words; done once.
- Request x0=5, x1=4: err pulses once, no bus_step edge, ready stays 1.
- Assert req again mid-fill with different coordinates: ignored, and the first fill completes unchanged.
- Assert rst after 7 transfers: all outputs return to reset values; a fresh request then restarts from register 0x02.
- With HX8352_STEP_TIMEOUT_EN and TIMEOUT=64, tie bus_busy=0: err pulses 64 cycles after the first step, no done pulse, FSM returns to IDLE.

Source files
------------

// File: rtl/hx8352_fill_sequencer.sv
// hx8352_fill_sequencer
//   Paints a solid-colour rectangle through the HX8352 bus controller.
//   One accepted request produces 16 window-register transfers
//   (command/data pairs for registers 0x02..0x09), the GRAM-write command
//   0x22, then N = (x1-x0+1)*(y1-y0+1) data words equal to color. Every
//   word is handed over with the step/busy handshake.
//
//   Optional build macro: HX8352_STEP_TIMEOUT_EN
//     When defined, a fill is abandoned with an err pulse if bus_busy
//     has not risen within TIMEOUT cycles of a step.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req             start request, sampled only while ready=1
//   x0/x1, y0/y1    inclusive window corners; color  RGB565 fill value
//   ready           idle and able to accept a request
//   done            one-cycle pulse after the last pixel transfer
//   err             one-cycle pulse on a rejected request or a timeout
//   bus_busy        busy from the bus controller
//   bus_data/bus_dc word and command(0)/data(1) flag to the bus controller
//   bus_step        one-cycle transfer strobe
//
// state       | meaning
// S_IDLE      | waiting for a request
// S_ARM       | request accepted, waiting for bus_busy=0 before first step
// S_ISSUE     | bus_step high for one cycle, word valid
// S_WAIT_ACK  | waiting for bus_busy to rise
// S_WAIT_DONE | waiting for bus_busy to fall, then advance
// S_FIN       | done pulse, back to idle next cycle
module hx8352_fill_sequencer #(
  parameter int X_W     = 9,
  parameter int Y_W     = 9,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic [15:0]    color,
  output logic           ready,
  output logic           done,
  output logic           err,
  input  logic           bus_busy,
  output logic [15:0]    bus_data,
  output logic           bus_dc,
  output logic           bus_step
);

  localparam int NW = X_W + Y_W;
  // List index: 0..15 window pairs, 16 = GRAM command, 17 = pixel phase.
  localparam logic [4:0] CMD_IDX = 5'd16;
  localparam logic [4:0] PIX_IDX = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_FIN
  } state_t;

  state_t         state, state_next;
  logic [4:0]     idx, idx_next;
  logic [NW-1:0]  pix_cnt, pix_next, pix_load;
  logic [X_W-1:0] x0_q, x1_q;
  logic [Y_W-1:0] y0_q, y1_q;
  logic [15:0]    color_q;
  logic [X_W:0]   dx;
  logic [Y_W:0]   dy;
  logic           latch, err_next, to_expire;
  logic [15:0]    word, coord;
  logic           word_dc;

  assign dx       = {1'b0, x1} - {1'b0, x0} + (X_W+1)'(1);
  assign dy       = {1'b0, y1} - {1'b0, y0} + (Y_W+1)'(1);
  assign pix_load = NW'(dx) * NW'(dy);

`ifdef HX8352_STEP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Loaded while stepping, so the last WAIT_ACK cycle with a count of 1
  // lands TIMEOUT-1 cycles after the step and err shows TIMEOUT cycles after it.
  assign to_expire = (state == S_WAIT_ACK) && !bus_busy && (to_cnt <= TO_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (state == S_ISSUE)
      to_cnt <= TO_W'(TIMEOUT - 1);
    else if (state == S_WAIT_ACK && to_cnt != '0)
      to_cnt <= to_cnt - TO_W'(1);
  end
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    pix_next   = pix_cnt;
    err_next   = 1'b0;
    latch      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ready && req) begin
          if (x1 < x0 || y1 < y0) begin
            err_next = 1'b1;
          end else begin
            latch      = 1'b1;
            idx_next   = 5'd0;
            pix_next   = pix_load;
            state_next = S_ARM;
          end
        end
      end
      S_ARM:   if (!bus_busy) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (bus_busy) begin
          state_next = S_WAIT_DONE;
        end else if (to_expire) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus_busy) begin
          if (idx != PIX_IDX) begin
            idx_next   = idx + 5'd1;
            state_next = S_ISSUE;
          end else if (pix_cnt == NW'(1)) begin
            pix_next   = '0;
            state_next = S_FIN;
          end else begin
            pix_next   = pix_cnt - NW'(1);
            state_next = S_ISSUE;
          end
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Word for the transfer about to be issued; odd window slots carry the
  // high byte (slot bit 1 clear) or low byte of the zero-extended coordinate.
  always_comb begin
    word    = 16'h0000;
    word_dc = 1'b0;
    case (idx_next[3:2])
      2'd0:    coord = 16'(x0_q);
      2'd1:    coord = 16'(x1_q);
      2'd2:    coord = 16'(y0_q);
      default: coord = 16'(y1_q);
    endcase
    if (idx_next == PIX_IDX) begin
      word    = color_q;
      word_dc = 1'b1;
    end else if (idx_next == CMD_IDX) begin
      word = 16'h0022;
    end else if (!idx_next[0]) begin
      word = 16'h0002 + {12'h000, idx_next[4:1]};
    end else begin
      word_dc = 1'b1;
      word    = idx_next[1] ? {8'h00, coord[7:0]} : {8'h00, coord[15:8]};
    end
  end

  assign done = (state == S_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= 5'd0;
      pix_cnt  <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      bus_step <= 1'b0;
      bus_dc   <= 1'b0;
      bus_data <= 16'h0000;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      color_q  <= 16'h0000;
    end else begin
      idx      <= idx_next;
      pix_cnt  <= pix_next;
      ready    <= (state_next == S_IDLE);
      err      <= err_next;
      bus_step <= (state_next == S_ISSUE);
      // Held until the next issue, so the word stays stable through busy.
      if (state_next == S_ISSUE) begin
        bus_data <= word;
        bus_dc   <= word_dc;
      end
      if (latch) begin
        x0_q    <= x0;
        x1_q    <= x1;
        y0_q    <= y0;
        y1_q    <= y1;
        color_q <= color;
      end
    end
  end

endmodule

// File: tb/tb_hx8352_fill_sequencer.sv
// Testbench for hx8352_fill_sequencer: table of fill requests with
// hand-computed pixel counts, plus directed sequences for reject, busy at
// start, request during a fill and reset mid-fill.
module tb_hx8352_fill_sequencer;

  typedef struct {
    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] color;
    int          n;
    bit          bad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [8:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [15:0] color = '0;
  logic        ready, done, err, bus_busy, bus_dc, bus_step;
  logic [15:0] bus_data;

  logic        model_busy = 1'b0;
  logic [1:0]  model_cnt = 2'd0;
  logic        busy_hold = 1'b0;
  logic        mute = 1'b0;

  int n_chk = 0, n_bad = 0;
  int cyc = 0;
  int n_done = 0, n_err = 0, n_rdy_bad = 0;
  int done_cyc = -1, rise_cyc = -1, err_cyc = -1;
  logic ready_prev = 1'b0;
  logic [16:0] log_w[$];
  int          log_c[$];
  vec_t vecs[6];

  assign bus_busy = model_busy | busy_hold;

  hx8352_fill_sequencer #(.X_W(9), .Y_W(9), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .ready(ready), .done(done), .err(err),
    .bus_busy(bus_busy), .bus_data(bus_data), .bus_dc(bus_dc), .bus_step(bus_step)
  );

  always #5 clk = ~clk;

  // Bus controller model: busy high for the two cycles after a step.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_cnt  <= 2'd0;
    end else if (bus_step && !mute) begin
      model_busy <= 1'b1;
      model_cnt  <= 2'd2;
    end else begin
      if (model_cnt != 2'd0) model_cnt <= model_cnt - 2'd1;
      model_busy <= (model_cnt == 2'd2);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (ready) n_rdy_bad++;
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
      if (!ready) n_rdy_bad++;
    end
    if (ready && !ready_prev) rise_cyc = cyc;
    ready_prev = ready;
    if (bus_step) begin
      log_w.push_back({bus_dc, bus_data});
      log_c.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] exp_word(input vec_t v, input int i);
    logic [15:0] c;
    if (i >= 17) return {1'b1, v.color};
    if (i == 16) return {1'b0, 16'h0022};
    case (i / 4)
      0:       c = {7'd0, v.x0};
      1:       c = {7'd0, v.x1};
      2:       c = {7'd0, v.y0};
      default: c = {7'd0, v.y1};
    endcase
    if (i % 2 == 0) return {1'b0, 16'(2 + i / 2)};
    return {1'b1, 8'h00, ((i % 4) == 1) ? c[15:8] : c[7:0]};
  endfunction

  task automatic clear_log();
    log_w.delete();
    log_c.delete();
    n_done = 0;
    n_err = 0;
    n_rdy_bad = 0;
    done_cyc = -1;
    err_cyc = -1;
  endtask

  task automatic apply_req(input vec_t v);
    @(negedge clk);
    x0 = v.x0; x1 = v.x1; y0 = v.y0; y1 = v.y1; color = v.color;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic finish_and_check(input vec_t v, input string tag);
    int budget = 60 + 4 * (17 + v.n);
    int wbad = 0, sbad = 0;
    while (n_done == 0 && n_err == 0 && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    check({tag, "/in_time"}, budget > 0, 1);
    repeat (10) @(posedge clk);
    #2;
    check({tag, "/err"}, n_err, v.bad ? 1 : 0);
    check({tag, "/done"}, n_done, v.bad ? 0 : 1);
    check({tag, "/xfers"}, log_w.size(), v.bad ? 0 : 17 + v.n);
    for (int i = 0; i < log_w.size(); i++)
      if (log_w[i] !== exp_word(v, i)) wbad++;
    check({tag, "/words"}, wbad, 0);
    for (int i = 1; i < log_c.size(); i++)
      if (log_c[i] - log_c[i-1] != 4) sbad++;
    check({tag, "/spacing"}, sbad, 0);
    check({tag, "/ready"}, ready, 1);
    check({tag, "/ready_at_pulse"}, n_rdy_bad, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    clear_log();
    apply_req(v);
    finish_and_check(v, tag);
  endtask

  initial begin
    logic [16:0] hand1[19];
    vec_t alt;
    int b;
    hand1 = '{17'h00002, 17'h10000, 17'h00003, 17'h1000A,
              17'h00004, 17'h10000, 17'h00005, 17'h1000B,
              17'h00006, 17'h10000, 17'h00007, 17'h10014,
              17'h00008, 17'h10000, 17'h00009, 17'h10014,
              17'h00022, 17'h1F800, 17'h1F800};

    vecs[0] = '{x0: 9'd10,  x1: 9'd11,  y0: 9'd20,  y1: 9'd20,  color: 16'hF800, n: 2, bad: 0};
    vecs[1] = '{x0: 9'd398, x1: 9'd399, y0: 9'd238, y1: 9'd239, color: 16'h001F, n: 4, bad: 0};
    vecs[2] = '{x0: 9'd5,   x1: 9'd5,   y0: 9'd7,   y1: 9'd7,   color: 16'h07E0, n: 1, bad: 0};
    vecs[3] = '{x0: 9'd5,   x1: 9'd4,   y0: 9'd0,   y1: 9'd0,   color: 16'hFFFF, n: 0, bad: 1};
    vecs[4] = '{x0: 9'd0,   x1: 9'd0,   y0: 9'd3,   y1: 9'd2,   color: 16'h0001, n: 0, bad: 1};
    vecs[5] = '{x0: 9'd0,   x1: 9'd2,   y0: 9'd0,   y1: 9'd1,   color: 16'h1234, n: 6, bad: 0};

    #1;
    check("reset_outputs", {ready, done, err, bus_step, bus_dc, bus_data}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_first_clk", ready, 0);
    @(posedge clk); #2;
    check("ready_after_first_clk", ready, 1);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Hand-listed sequence and done/ready timing for the first fill.
    run_vec(vecs[0], "hand");
    begin
      int hb = 0;
      for (int i = 0; i < 19 && i < log_w.size(); i++)
        if (log_w[i] !== hand1[i]) hb++;
      check("hand/list", hb, 0);
    end
    check("hand/ready_rise", rise_cyc - done_cyc, 1);
    // Register 0x04/0x05 data for x1=399.
    run_vec(vecs[1], "x399");
    check("x399/reg04", (log_w.size() > 5) ? log_w[5] : 17'h0, 17'h10001);
    check("x399/reg05", (log_w.size() > 7) ? log_w[7] : 17'h0, 17'h1008F);

    // Request during a fill is ignored.
    clear_log();
    apply_req(vecs[0]);
    repeat (8) @(posedge clk);
    @(negedge clk);
    x0 = 9'd0; x1 = 9'd100; y0 = 9'd1; y1 = 9'd50; color = 16'hAAAA;
    req = 1'b1;
    repeat (6) @(negedge clk);
    req = 1'b0;
    finish_and_check(vecs[0], "midreq");

    // bus_busy high while idle delays the first step.
    busy_hold = 1'b1;
    clear_log();
    apply_req(vecs[2]);
    repeat (12) @(posedge clk);
    #2;
    check("busyhold/no_step", log_w.size(), 0);
    check("busyhold/ready_low", ready, 0);
    @(negedge clk);
    busy_hold = 1'b0;
    finish_and_check(vecs[2], "busyhold");

    // Reset after 7 transfers, then a fresh fill from register 0x02.
    clear_log();
    apply_req(vecs[5]);
    b = 200;
    while (log_w.size() < 7 && b > 0) begin
      @(posedge clk); #2;
      b--;
    end
    check("rst/reached7", b > 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst/outputs", {ready, done, err, bus_step, bus_dc, bus_data}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst/no_done", n_done, 0);
    check("rst/ready_back", ready, 1);
    run_vec(vecs[5], "after_rst");

`ifdef HX8352_STEP_TIMEOUT_EN
    mute = 1'b1;
    clear_log();
    apply_req(vecs[2]);
    b = 300;
    while (n_err == 0 && b > 0) begin
      @(posedge clk); #2;
      b--;
    end
    check("timeout/in_time", b > 0, 1);
    repeat (5) @(posedge clk);
    #2;
    check("timeout/err", n_err, 1);
    check("timeout/no_done", n_done, 0);
    check("timeout/delay", (log_c.size() > 0) ? err_cyc - log_c[0] : -1, 64);
    check("timeout/ready", ready, 1);
    mute = 1'b0;
`endif

    alt = vecs[0];
    alt.color = 16'h0F0F;
    run_vec(alt, "final");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
